// File: rtl/handshake_fifo_break_dvr_pkg.sv
// ---------------------------------------------------------------------------
// handshake_fifo_break_dvr_pkg
//   Shared definitions for the handshake FIFO slice:
//     HS_CLOG2              pointer / count width helper (never returns < 1)
//     HS_DEFAULT_DATA_WIDTH default token payload width (32)
//     HS_FP16_WIDTH         width of fp16 constant tokens (16)
//     hs_xfer_e             encoding of {push, pop} for one clock edge
// ---------------------------------------------------------------------------
package handshake_fifo_break_dvr_pkg;

    localparam int HS_DEFAULT_DATA_WIDTH = 32;
    localparam int HS_FP16_WIDTH         = 16;

    // Bits needed to encode values 0..value-1. Clamped to 1 so that a
    // one-entry range still gets a real signal.
    function automatic int HS_CLOG2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // {push, pop} seen at one clock edge
    typedef enum logic [1:0] {
        XFER_IDLE = 2'b00,
        XFER_POP  = 2'b01,
        XFER_PUSH = 2'b10,
        XFER_BOTH = 2'b11
    } hs_xfer_e;

endpackage

// File: rtl/handshake_fifo_mem.sv
// ---------------------------------------------------------------------------
// handshake_fifo_mem
//   DATA_WIDTH x NUM_SLOTS register array backing the handshake FIFO.
//   Synchronous write, asynchronous (combinational) read. Not reset: the
//   FIFO's flags decide whether a slot's contents mean anything.
// Ports
//   clk    in   write clock, rising edge
//   we     in   write enable
//   waddr  in   write slot index (0..NUM_SLOTS-1)
//   wdata  in   write payload
//   raddr  in   read slot index (0..NUM_SLOTS-1)
//   rdata  out  payload stored at raddr
// ---------------------------------------------------------------------------
module handshake_fifo_mem
    import handshake_fifo_break_dvr_pkg::*;
#(
    parameter int DATA_WIDTH = HS_DEFAULT_DATA_WIDTH,
    parameter int NUM_SLOTS  = 2,
    parameter int ADDR_W     = HS_CLOG2(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0] mem_q;
    logic [NUM_SLOTS-1:0]                 slot_we;

    // One-hot slot enables decoded from the write address
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign slot_we[g] = we && (waddr == ADDR_W'(g));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_we[i]) mem_q[i] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/handshake_fifo_break_dvr.sv
// ---------------------------------------------------------------------------
// handshake_fifo_break_dvr
//   Elastic FIFO that breaks both the valid/data path and the ready path
//   between a handshake producer and its consumer. ins_ready and outs_valid
//   come straight from flops, so neither side sees a combinational path to
//   the other. Order is preserved; no token is lost or duplicated.
//
//   Optional feature macro: HANDSHAKE_FIFO_OCC_EN
//     defined   -> 'occupancy' output carries the registered token count
//     undefined -> port absent; behaviour otherwise identical
//
// Parameters
//   DATA_WIDTH  token payload width
//   NUM_SLOTS   depth in tokens (>= 2, any value; pointers wrap explicitly)
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   ins         in   input payload
//   ins_valid   in   input token present
//   ins_ready   out  FIFO can take a token (registered, = ~full)
//   outs        out  head payload, read from storage
//   outs_valid  out  FIFO holds a token (registered, = ~empty)
//   outs_ready  in   consumer takes the head token
//   occupancy   out  token count (HANDSHAKE_FIFO_OCC_EN only)
// ---------------------------------------------------------------------------
module handshake_fifo_break_dvr
    import handshake_fifo_break_dvr_pkg::*;
#(
    parameter int DATA_WIDTH = HS_DEFAULT_DATA_WIDTH,
    parameter int NUM_SLOTS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
`ifdef HANDSHAKE_FIFO_OCC_EN
    ,
    output logic [HS_CLOG2(NUM_SLOTS+1)-1:0] occupancy
`endif
);

    localparam int PTR_W = HS_CLOG2(NUM_SLOTS);
    localparam int CNT_W = HS_CLOG2(NUM_SLOTS + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    logic             push;
    logic             pop;
    hs_xfer_e         xfer;

    // Explicit wrap so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Both transfers are qualified only by registered flags, so the
    // ready seen by the producer never depends on this cycle's outs_ready.
    assign push = ins_valid  & ~full_q;
    assign pop  = outs_ready & ~empty_q;
    assign xfer = hs_xfer_e'({push, pop});

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case (xfer)
            XFER_PUSH: begin
                tail_d  = ptr_inc(tail_q);
                count_d = count_q + CNT_W'(1);
            end
            XFER_POP: begin
                head_d  = ptr_inc(head_q);
                count_d = count_q - CNT_W'(1);
            end
            XFER_BOTH: begin
                // Only reachable with 0 < count < NUM_SLOTS: count holds
                head_d  = ptr_inc(head_q);
                tail_d  = ptr_inc(tail_q);
            end
            default: ;
        endcase
        // Flags come from the next count so they can be registered
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    handshake_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLOTS  (NUM_SLOTS),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (tail_q),
        .wdata (ins),
        .raddr (head_q),
        .rdata (outs)
    );

    assign ins_ready  = ~full_q;
    assign outs_valid = ~empty_q;

`ifdef HANDSHAKE_FIFO_OCC_EN
    assign occupancy = count_q;
`endif

endmodule
